// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: valid/ready word handshake feeding the UART serialiser.
//   tx_valid  master -> slave  tx_data holds a word to send
//   tx_data   master -> slave  word to send, DATA_BITS wide
//   tx_ready  slave -> master  serialiser accepts a word this cycle
interface uart_tx_frame_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART serialiser. One word per valid/ready handshake is sent as a start bit,
// LSB-first data, optional parity and STOP_BITS stop bits, each bit CLKS_PER_BIT clocks long.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit (sense set by PARITY_ODD).
// Ports:
//   clock       system clock, all state on posedge
//   reset       asynchronous, active-high
//   tx          slave side of the word handshake (tx_valid, tx_data, tx_ready)
//   serial_out  registered UART line, idle high
//   busy        frame in progress
//   tx_done     one-cycle pulse in the last clock of the final stop bit
module uart_tx_frame #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 9,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic              clock,
    input  logic              reset,
    uart_tx_frame_if.slave    tx,
    output logic              serial_out,
    output logic              busy,
    output logic              tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

    localparam logic [BaudW-1:0] LastBaud = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  LastData = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0]  LastStop = BitW'(STOP_BITS - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [BaudW-1:0]     baud_q, baud_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 baud_wrap;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign baud_wrap = (baud_q == LastBaud);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != StIdle) begin
            baud_d = baud_wrap ? '0 : baud_q + BaudW'(1);
        end
        case (state_q)
            StIdle: begin
                if (tx.tx_valid) begin
                    state_d = StStart;
                    shift_d = tx.tx_data;
                    baud_d  = '0;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (PARITY_ODD != 0) ? ~^tx.tx_data : ^tx.tx_data;
`endif
                end
            end
            StStart: begin
                if (baud_wrap) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_wrap) begin
                    if (bit_q == LastData) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                        bit_d = '0;
                    end else begin
                        bit_d   = bit_q + BitW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_wrap) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (baud_wrap) begin
                    if (bit_q == LastStop) begin
                        state_d = StIdle;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the next state so it changes on the same edge as the state.
        case (state_d)
            StStart: serial_d = 1'b0;
            StData:  serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: serial_d = parity_d;
`endif
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx.tx_ready = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign tx_done     = (state_q == StStop) && baud_wrap && (bit_q == LastStop);
    assign serial_out  = serial_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame. DUT a uses STOP_BITS=1, DUT b STOP_BITS=2;
// both DATA_BITS=8, CLKS_PER_BIT=4. Expected line levels come from a frame-position model.
module tb_uart_tx_frame;

    localparam int unsigned Cpb   = 4;
    localparam int unsigned PodD  = 0;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       valid_drv = 1'b0;
    logic [7:0] data_drv = 8'h00;
    int         sel = 0;

    always #5 clock = ~clock;

    uart_tx_frame_if #(.DATA_BITS(8)) if_a ();
    uart_tx_frame_if #(.DATA_BITS(8)) if_b ();

    assign if_a.tx_valid = valid_drv && (sel == 0);
    assign if_a.tx_data  = data_drv;
    assign if_b.tx_valid = valid_drv && (sel == 1);
    assign if_b.tx_data  = data_drv;

    logic ser_a, busy_a, done_a;
    logic ser_b, busy_b, done_b;

    uart_tx_frame #(
        .DATA_BITS(8), .CLKS_PER_BIT(Cpb), .STOP_BITS(1), .PARITY_ODD(PodD)
    ) u_dut_a (
        .clock(clock), .reset(reset), .tx(if_a.slave),
        .serial_out(ser_a), .busy(busy_a), .tx_done(done_a)
    );

    uart_tx_frame #(
        .DATA_BITS(8), .CLKS_PER_BIT(Cpb), .STOP_BITS(2), .PARITY_ODD(PodD)
    ) u_dut_b (
        .clock(clock), .reset(reset), .tx(if_b.slave),
        .serial_out(ser_b), .busy(busy_b), .tx_done(done_b)
    );

    logic obs_ser, obs_busy, obs_done, obs_ready;
    assign obs_ser   = (sel == 0) ? ser_a  : ser_b;
    assign obs_busy  = (sel == 0) ? busy_a : busy_b;
    assign obs_done  = (sel == 0) ? done_a : done_b;
    assign obs_ready = (sel == 0) ? if_a.tx_ready : if_b.tx_ready;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line level in frame cycle k (k=1 is the first cycle after the accept edge).
    function automatic logic exp_bit(input int k, input logic [7:0] data);
        int idx;
        idx = (k - 1) / Cpb;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return data[idx-1];
        if (P == 1 && idx == 9) return (^data) ^ PodD[0];
        return 1'b1;
    endfunction

    // mode 0: drop valid after accept; 1: keep valid, change data to next_data;
    // 2: scramble data and valid every cycle during the frame.
    task automatic run_frame(input logic [7:0] data, input int stop_bits, input int mode,
                             input bit skip_accept, input logic [7:0] next_data);
        int len;
        len = (1 + 8 + P + stop_bits) * Cpb;
        if (!skip_accept) begin
            @(negedge clock);
            check_eq("accept_ready", {31'd0, obs_ready}, 32'd1);
            valid_drv = 1'b1;
            data_drv  = data;
        end
        for (int k = 1; k <= len; k++) begin
            @(negedge clock);
            check_eq($sformatf("ser d=%02h k=%0d", data, k), {31'd0, obs_ser},
                     {31'd0, exp_bit(k, data)});
            check_eq($sformatf("done d=%02h k=%0d", data, k), {31'd0, obs_done},
                     {31'd0, (k == len)});
            check_eq($sformatf("ready d=%02h k=%0d", data, k), {31'd0, obs_ready}, 32'd0);
            check_eq($sformatf("busy d=%02h k=%0d", data, k), {31'd0, obs_busy}, 32'd1);
            case (mode)
                0: valid_drv = 1'b0;
                1: data_drv = next_data;
                default: begin
                    data_drv  = 8'($urandom);
                    valid_drv = (k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            endcase
        end
        @(negedge clock);
        check_eq($sformatf("idle_ser d=%02h", data), {31'd0, obs_ser}, 32'd1);
        check_eq($sformatf("idle_ready d=%02h", data), {31'd0, obs_ready}, 32'd1);
        check_eq($sformatf("idle_busy d=%02h", data), {31'd0, obs_busy}, 32'd0);
        check_eq($sformatf("idle_done d=%02h", data), {31'd0, obs_done}, 32'd0);
    endtask

    initial begin
        // Reset state, then 20 idle cycles.
        repeat (2) @(negedge clock);
        check_eq("rst_ser", {31'd0, ser_a}, 32'd1);
        check_eq("rst_ready", {31'd0, if_a.tx_ready}, 32'd1);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_done", {31'd0, done_a}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_eq($sformatf("idle%0d", i),
                     {28'd0, ser_a, if_a.tx_ready, busy_a, done_a}, 32'b1100);
        end

        // Basic frame (with parity bit when the feature is built in).
        sel = 0;
        run_frame(8'hA5, 1, 0, 1'b0, 8'h00);

        // Input churn during a frame must not disturb it or cause an extra accept.
        run_frame(8'h3C, 1, 2, 1'b0, 8'h00);
        @(negedge clock);
        check_eq("no_extra_accept", {31'd0, obs_busy}, 32'd0);

        // Two stop bits, valid held: exactly one idle cycle between frames.
        sel = 1;
        run_frame(8'h00, 2, 1, 1'b0, 8'hFF);
        run_frame(8'hFF, 2, 0, 1'b1, 8'h00);

        // Asynchronous reset mid-frame.
        sel = 0;
        @(negedge clock);
        valid_drv = 1'b1;
        data_drv  = 8'h30;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            valid_drv = 1'b0;
        end
        check_eq("pre_rst_ser", {31'd0, ser_a}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_ser", {31'd0, ser_a}, 32'd1);
        check_eq("async_rst_ready", {31'd0, if_a.tx_ready}, 32'd1);
        check_eq("async_rst_busy", {31'd0, busy_a}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_eq($sformatf("post_rst%0d", i),
                     {28'd0, ser_a, if_a.tx_ready, busy_a, done_a}, 32'b1100);
        end
        run_frame(8'h3C, 1, 0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
